// File: rtl/extract_field_array.sv
// Time-multiplexed multi-field extractor: captures one PHV, pulls NUM_FIELDS slots
// chosen by a per-type config row using NUM_EXTRACTORS muxes over ROUNDS cycles.
module extract_field_array #(
    parameter int unsigned PHV_WIDTH      = 1024,
    parameter int unsigned EXTRACT_WIDTH  = 8,
    parameter int unsigned SLOT_NUM       = PHV_WIDTH / EXTRACT_WIDTH,
    parameter int unsigned OFFSET_WIDTH   = $clog2(SLOT_NUM),
    parameter int unsigned NUM_FIELDS     = 8,
    parameter int unsigned NUM_EXTRACTORS = 2,
    parameter int unsigned ROUNDS         = NUM_FIELDS / NUM_EXTRACTORS,
    parameter int unsigned TYPE_NUM       = 4,
    parameter int unsigned TYPE_WIDTH     = $clog2(TYPE_NUM),
    parameter int unsigned FIDX_WIDTH     = $clog2(NUM_FIELDS)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_phv_valid,
    output logic                                o_phv_ready,
    input  logic [PHV_WIDTH-1:0]                i_phv_data,
    input  logic [TYPE_WIDTH-1:0]               i_phv_type,
    output logic                                o_fields_valid,
    input  logic                                i_fields_ready,
    output logic [NUM_FIELDS*EXTRACT_WIDTH-1:0] o_fields_data,
    output logic [TYPE_WIDTH-1:0]               o_fields_type,
    input  logic                                i_cfg_wren,
    input  logic [TYPE_WIDTH-1:0]               i_cfg_type,
    input  logic [FIDX_WIDTH-1:0]               i_cfg_fidx,
    input  logic [OFFSET_WIDTH-1:0]             i_cfg_offset,
    input  logic                                i_cfg_en
);

    localparam int unsigned ROUND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    if ((NUM_FIELDS % NUM_EXTRACTORS) != 0) begin : g_bad_extractors
        $error("NUM_FIELDS must be a multiple of NUM_EXTRACTORS");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXTRACT = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [OFFSET_WIDTH-1:0]   cfg_off_q  [TYPE_NUM][NUM_FIELDS];
    logic [NUM_FIELDS-1:0]     cfg_en_q   [TYPE_NUM];
    logic [OFFSET_WIDTH-1:0]   work_off_q [NUM_FIELDS];
    logic [NUM_FIELDS-1:0]     work_en_q;
    logic [PHV_WIDTH-1:0]      phv_q;
    logic [TYPE_WIDTH-1:0]     type_q;
    logic [ROUND_W-1:0]        round_q;
    logic [EXTRACT_WIDTH-1:0]  res_q      [NUM_FIELDS];
    logic                      valid_q;
    logic                      ready_q;

    logic [EXTRACT_WIDTH-1:0]  slot_c     [SLOT_NUM];
    logic [FIDX_WIDTH-1:0]     fidx_c     [NUM_EXTRACTORS];
    logic [EXTRACT_WIDTH-1:0]  xval_c     [NUM_EXTRACTORS];
    logic                      cfg_hit_c;
    logic                      type_ok_c;
    logic                      capture_c;
    logic [NUM_FIELDS*EXTRACT_WIDTH-1:0] fields_c;

    for (genvar k = 0; k < SLOT_NUM; k++) begin : g_slot
        assign slot_c[k] = phv_q[k*EXTRACT_WIDTH +: EXTRACT_WIDTH];
    end

    assign cfg_hit_c = i_cfg_wren && (32'(i_cfg_type) < TYPE_NUM) && (32'(i_cfg_fidx) < NUM_FIELDS);
    assign type_ok_c = 32'(i_phv_type) < TYPE_NUM;
    assign capture_c = (state_q == ST_IDLE) && i_phv_valid;

    // Config table; a capture in the same cycle snapshots the pre-write row
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned t = 0; t < TYPE_NUM; t++) begin
                cfg_en_q[t] <= '0;
                for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                    cfg_off_q[t][f] <= '0;
                end
            end
        end else if (cfg_hit_c) begin
            cfg_off_q[i_cfg_type][i_cfg_fidx] <= i_cfg_offset;
            cfg_en_q[i_cfg_type][i_cfg_fidx]  <= i_cfg_en;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (i_phv_valid) state_d = ST_EXTRACT;
            ST_EXTRACT: if (round_q == ROUND_W'(ROUNDS - 1)) state_d = ST_OUTPUT;
            ST_OUTPUT:  if (i_fields_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == ST_OUTPUT);
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // Field index and slot mux per extractor for the current round
    always_comb begin
        for (int unsigned e = 0; e < NUM_EXTRACTORS; e++) begin
            fidx_c[e] = FIDX_WIDTH'(32'(round_q) * NUM_EXTRACTORS + e);
            xval_c[e] = '0;
            if (work_en_q[fidx_c[e]] && (32'(work_off_q[fidx_c[e]]) < SLOT_NUM)) begin
                xval_c[e] = slot_c[work_off_q[fidx_c[e]]];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phv_q     <= '0;
            type_q    <= '0;
            round_q   <= '0;
            work_en_q <= '0;
            for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                work_off_q[f] <= '0;
                res_q[f]      <= '0;
            end
        end else if (capture_c) begin
            phv_q   <= i_phv_data;
            type_q  <= i_phv_type;
            round_q <= '0;
            if (type_ok_c) begin
                work_en_q <= cfg_en_q[i_phv_type];
                for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                    work_off_q[f] <= cfg_off_q[i_phv_type][f];
                end
            end else begin
                work_en_q <= '0;
            end
        end else if (state_q == ST_EXTRACT) begin
            round_q <= round_q + ROUND_W'(1);
            for (int unsigned e = 0; e < NUM_EXTRACTORS; e++) begin
                res_q[fidx_c[e]] <= xval_c[e];
            end
        end
    end

    always_comb begin
        fields_c = '0;
        for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
            fields_c[f*EXTRACT_WIDTH +: EXTRACT_WIDTH] = res_q[f];
        end
    end

    assign o_fields_data  = fields_c;
    assign o_fields_type  = type_q;
    assign o_fields_valid = valid_q;
    // Ready is held low while reset is asserted, high in the first cycle after
    assign o_phv_ready    = ready_q & ~i_rst;

endmodule

// File: tb/tb_extract_field_array.sv
// Scoreboard bench for extract_field_array: default build plus a 1000-bit,
// eight-extractor build for the out-of-range slot and single-round latency.
module tb_extract_field_array;

    logic         clk;
    logic         i_rst;
    logic         i_phv_valid, o_phv_ready;
    logic [1023:0] i_phv_data;
    logic [1:0]   i_phv_type;
    logic         o_fields_valid, i_fields_ready;
    logic [63:0]  o_fields_data;
    logic [1:0]   o_fields_type;
    logic         i_cfg_wren;
    logic [1:0]   i_cfg_type;
    logic [2:0]   i_cfg_fidx;
    logic [6:0]   i_cfg_offset;
    logic         i_cfg_en;

    logic         phv_valid2, phv_ready2;
    logic [999:0] phv_data2;
    logic [1:0]   phv_type2;
    logic         fields_valid2, fields_ready2;
    logic [63:0]  fields_data2;
    logic [1:0]   fields_type2;
    logic         cfg_wren2;
    logic [1:0]   cfg_type2;
    logic [2:0]   cfg_fidx2;
    logic [6:0]   cfg_offset2;
    logic         cfg_en2;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  t;
        int          acc;
    } exp_s;

    exp_s sb[$];
    exp_s sb2[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_v = 1'b0;
    logic prev_v2 = 1'b0;
    exp_s mon_e;
    exp_s mon_e2;

    localparam logic [63:0] EXP_T1   = 64'h0140_0303_7F0A_0500;
    localparam logic [63:0] EXP_T2   = 64'h0900_0000_0000_0002;
    localparam logic [63:0] EXP_T3B  = 64'hFEBF_FCFC_80F5_FAFF;
    localparam logic [63:0] EXP_T4B  = 64'hFE9C_FCFC_EBF5_FAFF;
    localparam logic [63:0] EXP_T5   = 64'h0163_0303_140A_0500;
    localparam logic [63:0] EXP_DUT2 = 64'h0000_0000_0001_7D00;

    extract_field_array u_dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_phv_valid    (i_phv_valid),
        .o_phv_ready    (o_phv_ready),
        .i_phv_data     (i_phv_data),
        .i_phv_type     (i_phv_type),
        .o_fields_valid (o_fields_valid),
        .i_fields_ready (i_fields_ready),
        .o_fields_data  (o_fields_data),
        .o_fields_type  (o_fields_type),
        .i_cfg_wren     (i_cfg_wren),
        .i_cfg_type     (i_cfg_type),
        .i_cfg_fidx     (i_cfg_fidx),
        .i_cfg_offset   (i_cfg_offset),
        .i_cfg_en       (i_cfg_en)
    );

    extract_field_array #(
        .PHV_WIDTH      (1000),
        .NUM_EXTRACTORS (8)
    ) u_dut2 (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_phv_valid    (phv_valid2),
        .o_phv_ready    (phv_ready2),
        .i_phv_data     (phv_data2),
        .i_phv_type     (phv_type2),
        .o_fields_valid (fields_valid2),
        .i_fields_ready (fields_ready2),
        .o_fields_data  (fields_data2),
        .o_fields_type  (fields_type2),
        .i_cfg_wren     (cfg_wren2),
        .i_cfg_type     (cfg_type2),
        .i_cfg_fidx     (cfg_fidx2),
        .i_cfg_offset   (cfg_offset2),
        .i_cfg_en       (cfg_en2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the default build: latency on rising valid, payload on handshake
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_fields_valid && !prev_v) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid actual=1 required=0 cyc=%0d", cyc);
                end else if (cyc - sb[0].acc != 4) begin
                    errors++;
                    $display("FAIL latency actual=%0d required=4", cyc - sb[0].acc);
                end
            end
            if (o_fields_valid && i_fields_ready && sb.size() != 0) begin
                mon_e = sb.pop_front();
                checks += 2;
                if (o_fields_data !== mon_e.d) begin
                    errors++;
                    $display("FAIL fields_data actual=%h required=%h", o_fields_data, mon_e.d);
                end
                if (o_fields_type !== mon_e.t) begin
                    errors++;
                    $display("FAIL fields_type actual=%0d required=%0d", o_fields_type, mon_e.t);
                end
            end
        end
        prev_v = o_fields_valid;
    end

    always @(negedge clk) begin
        if (!i_rst) begin
            if (fields_valid2 && !prev_v2) begin
                checks++;
                if (sb2.size() == 0) begin
                    errors++;
                    $display("FAIL dut2_unexpected_valid actual=1 required=0");
                end else if (cyc - sb2[0].acc != 1) begin
                    errors++;
                    $display("FAIL dut2_latency actual=%0d required=1", cyc - sb2[0].acc);
                end
            end
            if (fields_valid2 && fields_ready2 && sb2.size() != 0) begin
                mon_e2 = sb2.pop_front();
                checks += 2;
                if (fields_data2 !== mon_e2.d) begin
                    errors++;
                    $display("FAIL dut2_fields_data actual=%h required=%h", fields_data2, mon_e2.d);
                end
                if (fields_type2 !== mon_e2.t) begin
                    errors++;
                    $display("FAIL dut2_fields_type actual=%0d required=%0d", fields_type2, mon_e2.t);
                end
            end
        end
        prev_v2 = fields_valid2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] t, input logic [2:0] f, input logic [6:0] off, input logic en);
        i_cfg_wren = 1'b1; i_cfg_type = t; i_cfg_fidx = f; i_cfg_offset = off; i_cfg_en = en;
        step(1);
        i_cfg_wren = 1'b0;
    endtask

    // pattern 0: slot k = k ; pattern 1: slot k = 255-k
    task automatic drive_phv(input int pattern, input logic [1:0] t);
        for (int k = 0; k < 128; k++) begin
            i_phv_data[k*8 +: 8] = (pattern == 0) ? 8'(k) : 8'(255 - k);
        end
        i_phv_type  = t;
        i_phv_valid = 1'b1;
    endtask

    task automatic accept(input logic [63:0] d, input logic [1:0] t, output int waited);
        int  n = 0;
        bit  got = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (o_phv_ready) got = 1;
            else n++;
        end
        waited = n;
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_ready required=ready");
            i_phv_valid = 1'b0;
        end else begin
            step(1);
            i_phv_valid = 1'b0;
            sb.push_back('{d, t, cyc});
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || sb2.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || sb2.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size() + sb2.size());
            sb.delete(); sb2.delete();
        end
        step(1);
    endtask

    initial begin
        int n;
        logic [6:0] offs [8];
        offs = '{7'd0, 7'd5, 7'd10, 7'd127, 7'd3, 7'd3, 7'd64, 7'd1};

        i_rst = 1'b1; i_phv_valid = 1'b0; i_phv_data = '0; i_phv_type = '0;
        i_fields_ready = 1'b1; i_cfg_wren = 1'b0; i_cfg_type = '0; i_cfg_fidx = '0;
        i_cfg_offset = '0; i_cfg_en = 1'b0;
        phv_valid2 = 1'b0; phv_data2 = '0; phv_type2 = '0; fields_ready2 = 1'b1;
        cfg_wren2 = 1'b0; cfg_type2 = '0; cfg_fidx2 = '0; cfg_offset2 = '0; cfg_en2 = 1'b0;

        // Reset values
        step(3);
        @(negedge clk);
        check("rst_ready", 64'(o_phv_ready), 64'd0);
        check("rst_valid", 64'(o_fields_valid), 64'd0);
        check("rst_data", o_fields_data, 64'd0);
        check("rst_type", 64'(o_fields_type), 64'd0);
        step(1);
        i_rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(o_phv_ready), 64'd1);
        step(1);

        for (int f = 0; f < 8; f++) cfg(2'd1, 3'(f), offs[f], 1'b1);
        cfg(2'd2, 3'd0, 7'd2, 1'b1);
        cfg(2'd2, 3'd7, 7'd9, 1'b1);
        cfg(2'd2, 3'd3, 7'd50, 1'b0);

        // All-enabled row with duplicate offsets, then a sparse row
        drive_phv(0, 2'd1); accept(EXP_T1, 2'd1, n); drain();
        drive_phv(0, 2'd2); accept(EXP_T2, 2'd2, n); drain();

        // Backpressure: output held, a waiting PHV is not taken until release
        i_fields_ready = 1'b0;
        drive_phv(0, 2'd1); accept(EXP_T1, 2'd1, n);
        drive_phv(1, 2'd1);
        n = 0;
        while (!o_fields_valid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            check("hold_valid", 64'(o_fields_valid), 64'd1);
            check("hold_ready", 64'(o_phv_ready), 64'd0);
            check("hold_data", o_fields_data, EXP_T1);
            check("hold_type", 64'(o_fields_type), 64'd1);
        end
        step(1);
        i_fields_ready = 1'b1;
        accept(EXP_T3B, 2'd1, n);
        check("release_to_idle_cycles", 64'(n), 64'd1);
        drain();

        // Config writes at capture and mid-extraction only affect later PHVs
        step(2);
        i_cfg_wren = 1'b1; i_cfg_type = 2'd1; i_cfg_fidx = 3'd3; i_cfg_offset = 7'd20; i_cfg_en = 1'b1;
        drive_phv(0, 2'd1);
        accept(EXP_T1, 2'd1, n);
        i_cfg_wren = 1'b0;
        check("accept_same_cycle_as_cfg", 64'(n), 64'd0);
        step(1);
        cfg(2'd1, 3'd6, 7'd99, 1'b1);
        drain();
        drive_phv(1, 2'd1); accept(EXP_T4B, 2'd1, n); drain();

        // Reset during round 2 drops the PHV and clears config
        step(1);
        drive_phv(0, 2'd1); accept(EXP_T5, 2'd1, n);
        step(2);
        i_rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_ready", 64'(o_phv_ready), 64'd0);
        step(1);
        i_rst = 1'b0;
        @(negedge clk);
        check("postrst_valid", 64'(o_fields_valid), 64'd0);
        check("postrst_ready", 64'(o_phv_ready), 64'd1);
        check("postrst_data", o_fields_data, 64'd0);
        check("postrst_type", 64'(o_fields_type), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("postrst_no_output", 64'(o_fields_valid), 64'd0);
        end
        step(1);
        drive_phv(0, 2'd1); accept(64'd0, 2'd1, n); drain();

        // 125-slot build: offset 125 is out of range, single-round latency
        cfg_wren2 = 1'b1; cfg_type2 = 2'd0; cfg_fidx2 = 3'd0; cfg_offset2 = 7'd125; cfg_en2 = 1'b1;
        step(1);
        cfg_fidx2 = 3'd1; cfg_offset2 = 7'd124;
        step(1);
        cfg_fidx2 = 3'd2; cfg_offset2 = 7'd0;
        step(1);
        cfg_wren2 = 1'b0;
        for (int k = 0; k < 125; k++) phv_data2[k*8 +: 8] = 8'(k + 1);
        phv_type2 = 2'd0;
        phv_valid2 = 1'b1;
        n = 0;
        while (!phv_ready2 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        if (!phv_ready2) begin
            checks++; errors++;
            $display("FAIL dut2_accept_timeout actual=no_ready required=ready");
        end
        step(1);
        phv_valid2 = 1'b0;
        sb2.push_back('{EXP_DUT2, 2'd0, cyc});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/extract_field_array.md
Name: extract_field_array

Overview:
- Multi-field, time-multiplexed field extractor for the 3-stage parser.
- Accepts one PHV plus its header type and extracts NUM_FIELDS fields, each EXTRACT_WIDTH bits wide.
- Field offsets and enables come from a per-type configuration table, written through a config port.
- NUM_EXTRACTORS slot muxes are reused over several rounds. Results are presented on a valid/ready output.

Parameters:
- PHV_WIDTH, 1024, width of the PHV data bus.
- EXTRACT_WIDTH, 8, width of one extracted field and of one slot.
- SLOT_NUM, PHV_WIDTH/EXTRACT_WIDTH, number of addressable slots in the PHV.
- OFFSET_WIDTH, $clog2(SLOT_NUM), width of a slot offset.
- NUM_FIELDS, 8, number of fields extracted per PHV.
- NUM_EXTRACTORS, 2, number of parallel slot muxes. NUM_FIELDS must be a multiple of it; elaboration fails otherwise.
- ROUNDS, NUM_FIELDS/NUM_EXTRACTORS, number of extraction cycles per PHV.
- TYPE_NUM, 4, number of header types (rows in the config table).
- TYPE_WIDTH, $clog2(TYPE_NUM), width of a header type.
- FIDX_WIDTH, $clog2(NUM_FIELDS), width of a field index.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_phv_valid  in  1  input PHV valid.
- o_phv_ready  out  1  block can accept a PHV.
- i_phv_data  in  PHV_WIDTH  PHV; slot k = bits [k*EXTRACT_WIDTH +: EXTRACT_WIDTH].
- i_phv_type  in  TYPE_WIDTH  header type; selects the config row.
- o_fields_valid  out  1  result valid.
- i_fields_ready  in  1  downstream accepts the result.
- o_fields_data  out  NUM_FIELDS*EXTRACT_WIDTH  field f at [f*EXTRACT_WIDTH +: EXTRACT_WIDTH].
- o_fields_type  out  TYPE_WIDTH  type of the PHV that produced the result.
- i_cfg_wren  in  1  config write strobe.
- i_cfg_type  in  TYPE_WIDTH  config row to write.
- i_cfg_fidx  in  FIDX_WIDTH  field index to write.
- i_cfg_offset  in  OFFSET_WIDTH  slot offset for that field.
- i_cfg_en  in  1  field enable.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE.
  - Every config entry: offset=0, en=0.
  - o_fields_valid=0, o_fields_data=0, o_fields_type=0, internal PHV/type/round registers=0.
  - o_phv_ready=0 during reset and 1 in the first cycle after.
  - Reset mid-operation drops the in-flight PHV with no output.
- Config writes:
  - i_cfg_wren=1 writes {offset,en} to entry [i_cfg_type][i_cfg_fidx] at the clock edge. Accepted in any state.
  - fidx >= NUM_FIELDS or type >= TYPE_NUM: write ignored.
- FSM states IDLE, EXTRACT, OUTPUT; o_phv_ready = (state==IDLE).
  - IDLE: on i_phv_valid, capture i_phv_data and i_phv_type, snapshot the config row of i_phv_type into working registers, set round=0, go to EXTRACT.
  - Snapshot rule: if a config write and a capture occur in the same cycle, the snapshot takes the pre-write value. Config writes after capture affect only later PHVs.
  - EXTRACT: each cycle, extractor e computes field f = round*NUM_EXTRACTORS+e.
    - Result = captured slot[offset_f] if en_f=1 and offset_f < SLOT_NUM; otherwise 0.
    - Result is written into the result register f.
    - round increments; after the round ROUNDS-1 cycle, go to OUTPUT.
  - OUTPUT: o_fields_valid=1; o_fields_data and o_fields_type are stable while i_fields_ready=0.
    - On i_fields_ready=1: o_fields_valid=0 next cycle, go to IDLE.
- Timing:
  - Latency: PHV accepted at edge T → o_fields_valid high from cycle T+ROUNDS (ROUNDS EXTRACT cycles).
  - Minimum spacing between accepted PHVs: ROUNDS+2 cycles.
- Result registers:
  - Outside OUTPUT they hold the previous result.
  - Each field is overwritten exactly once per PHV, so no stale field survives into a new result.
- i_phv_valid outside IDLE is not accepted; the upstream holds it.
- Output registers only; no combinational path from i_fields_ready or i_phv_valid to o_phv_ready.
- Duplicate offsets across fields are legal; each such field gets the same slot.

Test Plan:
- Reset, config type 1: fields 0..7 = offsets {0,5,10,127,3,3,64,1}, all enabled. PHV slot k = k, type 1 → result {0,5,10,127,3,3,64,1}, type 1, valid exactly 4 cycles after accept.
- Type 2 with only fields 0 and 7 enabled (offsets 2 and 9) → field0=2, field7=9, fields 1..6=0.
- Hold i_fields_ready=0 for 10 cycles in OUTPUT → data/type stable, o_phv_ready=0, new i_phv_valid ignored; ready=1 → IDLE next cycle, then the next PHV is accepted.
- Config write to type 1 field 3 offset 20, issued in the accept cycle and again mid-EXTRACT → current result field3=127; next type 1 PHV gives field3=20.
- Assert i_rst during round 2 → no o_fields_valid; after reset all entries disabled, so a PHV yields all-zero fields.
- PHV_WIDTH=1000 (SLOT_NUM=125), offset 125 enabled → field=0. Also NUM_EXTRACTORS=8 → latency 1 cycle into OUTPUT.
